// File: rtl/prog_loader.sv
// Byte-stream boot loader: parses framed load commands and writes bytes into instruction or
// data memory through a registered byte-wide port, holding the CPU in reset until RUN arrives.
module prog_loader #(
    parameter int unsigned ADDR_BYTES = 2,
    parameter int unsigned LEN_BYTES  = 2,
    parameter int unsigned IMEM_DEPTH = 1024,
    parameter int unsigned DMEM_DEPTH = 1024,
    localparam int unsigned AW = 8 * ADDR_BYTES,
    localparam int unsigned LW = 8 * LEN_BYTES
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          imem_we,
    output logic          dmem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    output logic          cpu_hold,
    output logic          busy,
    output logic          err_cmd,
    output logic          err_csum,
    output logic          err_range,
    output logic [15:0]   frames_ok
);

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StLen,
        StData,
        StCsum,
        StRun
    } state_t;

    state_t        state;
    logic          tgt_dmem;
    logic [AW-1:0] addr_q;
    logic [LW-1:0] len_q;
    logic [7:0]    fcnt;
    logic [7:0]    sum;

    logic          accept;
    logic [7:0]    sum_next;
    logic [AW-1:0] addr_shift;
    logic [LW-1:0] len_shift;
    logic          in_range;
    logic          last_addr_byte;
    logic          last_len_byte;

    always_comb begin
        accept         = in_valid & in_ready;
        sum_next       = sum + in_data;
        addr_shift     = (addr_q << 8) | AW'(in_data);
        len_shift      = (len_q << 8) | LW'(in_data);
        last_addr_byte = (fcnt == 8'(ADDR_BYTES - 1));
        last_len_byte  = (fcnt == 8'(LEN_BYTES - 1));
        // Compare at 64 bits so depths up to and beyond 2^AW behave correctly.
        in_range       = 64'(addr_q) < 64'(tgt_dmem ? DMEM_DEPTH : IMEM_DEPTH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            tgt_dmem  <= 1'b0;
            addr_q    <= '0;
            len_q     <= '0;
            fcnt      <= '0;
            sum       <= '0;
            in_ready  <= 1'b0;
            imem_we   <= 1'b0;
            dmem_we   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_hold  <= 1'b1;
            busy      <= 1'b0;
            err_cmd   <= 1'b0;
            err_csum  <= 1'b0;
            err_range <= 1'b0;
            frames_ok <= '0;
        end else begin
            imem_we <= 1'b0;
            dmem_we <= 1'b0;
            if (state != StRun) begin
                in_ready <= 1'b1;
            end
            if (accept) begin
                case (state)
                    StIdle: begin
                        if (in_data[7:1] == 7'd0) begin
                            tgt_dmem <= in_data[0];
                            sum      <= in_data;
                            fcnt     <= '0;
                            addr_q   <= '0;
                            len_q    <= '0;
                            busy     <= 1'b1;
                            state    <= StAddr;
                        end else if (in_data == 8'hFF) begin
                            in_ready <= 1'b0;
                            cpu_hold <= 1'b0;
                            state    <= StRun;
                        end else begin
                            err_cmd <= 1'b1;
                        end
                    end
                    StAddr: begin
                        addr_q <= addr_shift;
                        sum    <= sum_next;
                        if (last_addr_byte) begin
                            fcnt  <= '0;
                            state <= StLen;
                        end else begin
                            fcnt <= fcnt + 8'd1;
                        end
                    end
                    StLen: begin
                        len_q <= len_shift;
                        sum   <= sum_next;
                        if (last_len_byte) begin
                            fcnt  <= '0;
                            state <= (len_shift == '0) ? StCsum : StData;
                        end else begin
                            fcnt <= fcnt + 8'd1;
                        end
                    end
                    StData: begin
                        sum <= sum_next;
                        // Out-of-range bytes still consume length and checksum.
                        if (in_range) begin
                            imem_we   <= ~tgt_dmem;
                            dmem_we   <= tgt_dmem;
                            mem_addr  <= addr_q;
                            mem_wdata <= in_data;
                        end else begin
                            err_range <= 1'b1;
                        end
                        addr_q <= addr_q + AW'(1);
                        len_q  <= len_q - LW'(1);
                        if (len_q == LW'(1)) begin
                            state <= StCsum;
                        end
                    end
                    StCsum: begin
                        if (sum_next == 8'd0) begin
                            frames_ok <= frames_ok + 16'd1;
                        end else begin
                            err_csum <= 1'b1;
                        end
                        busy  <= 1'b0;
                        state <= StIdle;
                    end
                    StRun: begin
                        state <= StRun;
                    end
                    default: begin
                        state <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed and randomized frames checked against a frame-level model.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        imem_we;
    logic        dmem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        err_cmd;
    logic        err_csum;
    logic        err_range;
    logic [15:0] frames_ok;

    prog_loader dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .imem_we   (imem_we),
        .dmem_we   (dmem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .err_cmd   (err_cmd),
        .err_csum  (err_csum),
        .err_range (err_range),
        .frames_ok (frames_ok)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_d;
        logic [15:0] a;
        logic [7:0]  d;
        int unsigned c;
    } wr_t;

    wr_t         obs_q[$];
    wr_t         exp_q[$];
    wr_t         mon_w;
    logic [7:0]  frm[$];
    int unsigned cyc = 0;
    int          both_we = 0;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    logic [15:0] m_frames_ok = 16'd0;
    logic        m_err_cmd = 1'b0;
    logic        m_err_csum = 1'b0;
    logic        m_err_range = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (imem_we || dmem_we) begin
            mon_w.is_d = dmem_we;
            mon_w.a    = mem_addr;
            mon_w.d    = mem_wdata;
            mon_w.c    = cyc;
            obs_q.push_back(mon_w);
            if (imem_we && dmem_we) both_we++;
        end
    end

    // Frame-level model: decodes the whole frame from its bytes at once.
    task automatic model_frame();
        logic [7:0]  s;
        int unsigned a;
        int unsigned n;
        wr_t         w;
        if (frm[0] > 8'h01) begin
            m_err_cmd = 1'b1;
        end else begin
            a = {frm[1], frm[2]};
            n = {frm[3], frm[4]};
            s = 8'd0;
            foreach (frm[i]) s = s + frm[i];
            for (int i = 0; i < int'(n); i++) begin
                w.is_d = frm[0][0];
                w.a    = 16'((a + i) % 65536);
                w.d    = frm[5 + i];
                w.c    = 0;
                if (w.a < 16'd1024) exp_q.push_back(w);
                else m_err_range = 1'b1;
            end
            if (s == 8'd0) m_frames_ok = m_frames_ok + 16'd1;
            else m_err_csum = 1'b1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            total_cnt++;
            $display("FAIL ready_timeout: in_ready=%b after %0d cycles, required 1", in_ready, t);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
    endtask

    // mode 0: back-to-back, 1: in_valid toggling, 2: random gaps.
    task automatic run_frame(input string name, input int mode, input bit b2b);
        send_byte(frm[0]);
        #1;
        total_cnt++;
        if (busy !== (frm[0] <= 8'h01))
            $display("FAIL %s busy_after_cmd: got %b, required %b", name, busy, frm[0] <= 8'h01);
        else pass_cnt++;
        for (int i = 1; i < frm.size(); i++) begin
            if (mode == 1) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_data  = 8'($urandom);
            end else if (mode == 2) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                    in_data  = 8'($urandom);
                end
            end
            send_byte(frm[i]);
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        model_frame();
        total_cnt++;
        if (obs_q.size() != exp_q.size())
            $display("FAIL %s write_count: got %0d, required %0d", name, obs_q.size(), exp_q.size());
        else pass_cnt++;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            total_cnt++;
            if (obs_q[i].is_d !== exp_q[i].is_d || obs_q[i].a !== exp_q[i].a ||
                obs_q[i].d !== exp_q[i].d)
                $display("FAIL %s write%0d: got dmem=%b addr=%h data=%h, required dmem=%b addr=%h data=%h",
                         name, i, obs_q[i].is_d, obs_q[i].a, obs_q[i].d,
                         exp_q[i].is_d, exp_q[i].a, exp_q[i].d);
            else pass_cnt++;
            if (b2b && i > 0) begin
                total_cnt++;
                if (obs_q[i].c != obs_q[i-1].c + 1)
                    $display("FAIL %s strobe_gap%0d: got cycle %0d, required %0d",
                             name, i, obs_q[i].c, obs_q[i-1].c + 1);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if ({err_cmd, err_csum, err_range} !== {m_err_cmd, m_err_csum, m_err_range})
            $display("FAIL %s errs: got cmd/csum/range=%b%b%b, required %b%b%b", name,
                     err_cmd, err_csum, err_range, m_err_cmd, m_err_csum, m_err_range);
        else pass_cnt++;
        total_cnt++;
        if (frames_ok !== m_frames_ok)
            $display("FAIL %s frames_ok: got %0d, required %0d", name, frames_ok, m_frames_ok);
        else pass_cnt++;
        total_cnt++;
        if ({busy, cpu_hold, in_ready} !== 3'b011 || both_we != 0)
            $display("FAIL %s idle_outputs: got busy=%b cpu_hold=%b in_ready=%b both_we=%0d, required 0 1 1 0",
                     name, busy, cpu_hold, in_ready, both_we);
        else pass_cnt++;
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        #12;
        total_cnt++;
        if ({in_ready, imem_we, dmem_we, mem_addr, mem_wdata, cpu_hold, busy,
             err_cmd, err_csum, err_range, frames_ok} !== {3'b000, 16'd0, 8'd0, 2'b10, 3'b000, 16'd0})
            $display("FAIL reset_values: got ready=%b imem=%b dmem=%b addr=%h data=%h hold=%b busy=%b",
                     in_ready, imem_we, dmem_we, mem_addr, mem_wdata, cpu_hold, busy);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        total_cnt++;
        if (in_ready !== 1'b1 || cpu_hold !== 1'b1)
            $display("FAIL reset_release: got in_ready=%b cpu_hold=%b, required 1 1", in_ready, cpu_hold);
        else pass_cnt++;
    endtask

    task automatic load_imem_frame(input logic [7:0] csum);
        frm = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h04, 8'h0C, 8'h00, 8'h00, 8'h05, csum};
    endtask

    task automatic test_imem_load();
        load_imem_frame(8'hEB);
        run_frame("imem_load", 0, 1'b1);
    endtask

    task automatic test_dmem_toggle();
        frm = '{8'h01, 8'h00, 8'h07, 8'h00, 8'h01, 8'h28, 8'hCF};
        run_frame("dmem_toggle", 1, 1'b0);
    endtask

    task automatic test_bad_csum();
        load_imem_frame(8'h00);
        run_frame("bad_csum", 0, 1'b1);
        load_imem_frame(8'hEB);
        run_frame("good_after_bad", 2, 1'b0);
    endtask

    task automatic test_range();
        frm = '{8'h00, 8'h03, 8'hFF, 8'h00, 8'h02, 8'hAA, 8'hBB, 8'h97};
        run_frame("range", 0, 1'b0);
    endtask

    task automatic test_bad_cmd();
        frm = '{8'h42};
        run_frame("bad_cmd", 0, 1'b0);
        frm = '{8'h01, 8'h00, 8'h10, 8'h00, 8'h00, 8'hEF};
        run_frame("zero_len_after_bad_cmd", 0, 1'b0);
    endtask

    task automatic test_random();
        logic [15:0] a;
        int          n;
        logic [7:0]  s;
        for (int f = 0; f < 10; f++) begin
            case ($urandom_range(0, 2))
                0:       a = 16'($urandom_range(0, 1100));
                1:       a = 16'($urandom_range(1018, 1026));
                default: a = 16'hFFFE;
            endcase
            n = $urandom_range(0, 5);
            frm.delete();
            frm.push_back(8'($urandom_range(0, 1)));
            frm.push_back(a[15:8]);
            frm.push_back(a[7:0]);
            frm.push_back(8'd0);
            frm.push_back(8'(n));
            for (int i = 0; i < n; i++) frm.push_back(8'($urandom));
            s = 8'd0;
            foreach (frm[i]) s = s + frm[i];
            if ($urandom_range(0, 3) == 0) frm.push_back(8'(8'd0 - s + 8'($urandom_range(1, 255))));
            else frm.push_back(8'(8'd0 - s));
            run_frame("random", 2, 1'b0);
        end
    endtask

    task automatic test_reset_mid();
        load_imem_frame(8'hEB);
        for (int i = 0; i < 7; i++) send_byte(frm[i]);
        #2;
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({in_ready, imem_we, dmem_we, mem_addr, mem_wdata, cpu_hold, busy,
             err_cmd, err_csum, err_range, frames_ok} !== {3'b000, 16'd0, 8'd0, 2'b10, 3'b000, 16'd0})
            $display("FAIL reset_mid: got ready=%b imem=%b addr=%h data=%h busy=%b errs=%b%b%b frames=%0d",
                     in_ready, imem_we, mem_addr, mem_wdata, busy, err_cmd, err_csum, err_range,
                     frames_ok);
        else pass_cnt++;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        obs_q.delete();
        m_frames_ok = 16'd0;
        m_err_cmd   = 1'b0;
        m_err_csum  = 1'b0;
        m_err_range = 1'b0;
        load_imem_frame(8'hEB);
        run_frame("after_reset_mid", 0, 1'b1);
    endtask

    task automatic test_run();
        send_byte(8'hFF);
        #1;
        total_cnt++;
        if (cpu_hold !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL run_enter: got cpu_hold=%b in_ready=%b, required 0 0", cpu_hold, in_ready);
        else pass_cnt++;
        repeat (8) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'($urandom_range(0, 1));
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (obs_q.size() != 0 || busy !== 1'b0 || frames_ok !== m_frames_ok ||
            cpu_hold !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL run_ignores: got writes=%0d busy=%b frames=%0d hold=%b ready=%b, required 0 0 %0d 0 0",
                     obs_q.size(), busy, frames_ok, cpu_hold, in_ready, m_frames_ok);
        else pass_cnt++;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (cpu_hold !== 1'b1)
            $display("FAIL run_reset: got cpu_hold=%b, required 1", cpu_hold);
        else pass_cnt++;
        #20;
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_imem_load();
        test_dmem_toggle();
        test_bad_csum();
        test_range();
        test_bad_cmd();
        test_random();
        test_reset_mid();
        test_run();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
